// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the step-counter width helper.
package sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-step configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int bpc);
        int steps;
        steps = width / bpc;
        return (steps < 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: difference and borrow-out from a - b - br.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic d,
    output logic br_out
);

    assign d      = a ^ b ^ br;
    assign br_out = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor computing a - b - bin, BPC bits per clock, LSB first,
// with borrow carried in a register between steps.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = cnt_width(WIDTH, BPC);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [BPC-1:0]   d_vec;
    logic [BPC:0]     br_chain;
    logic [WIDTH-1:0] d_ext;
    logic [WIDTH-1:0] res_nxt;

    assign br_chain[0] = br_q;

    for (genvar i = 0; i < BPC; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a      (a_q[i]),
            .b      (b_q[i]),
            .br     (br_chain[i]),
            .d      (d_vec[i]),
            .br_out (br_chain[i+1])
        );
    end

    // New difference bits enter at the top so the result ends up LSB-aligned.
    always_comb begin
        d_ext          = '0;
        d_ext[BPC-1:0] = d_vec;
        res_nxt        = (res_q >> BPC) | (d_ext << (WIDTH - BPC));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end
            end
            ST_RUN: begin
                a_d   = a_q >> BPC;
                b_d   = b_q >> BPC;
                br_d  = br_chain[BPC];
                res_d = res_nxt;
                // The counter holds on the last step; only a start reloads it.
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    diff_d  = res_nxt;
                    bout_d  = br_chain[BPC];
                    zero_d  = (res_nxt == '0);
                    ovf_d   = (a_msb_q != b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule
